instruction_encoder: RTL

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instr_pkg.sv | 39 +++
 rtl/instr_field_pack.sv | 63 ++++++
 rtl/instruction_encoder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// rtl/instr_pkg.sv - shared types, constants and field positions for the instruction encoder
package instr_pkg;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'd0,
        CLS_MEM  = 2'd1,
        CLS_BX   = 2'd2,
        CLS_HALT = 2'd3
    } instr_class_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TERM = 2'd2,
        ST_DONE = 2'd3
    } enc_state_t;

    localparam logic [23:0] BX_PATTERN = 24'h12FFF1;
    localparam logic [31:0] HALT_WORD  = 32'd0;
    localparam logic [4:0]  MEM_FIXED  = 5'b01100;

    localparam logic [1:0]  TYPE_ALU   = 2'b00;
    localparam logic [1:0]  TYPE_MEM   = 2'b01;

    // Least-significant bit of each field within the 32-bit word
    localparam int COND_LSB  = 28;
    localparam int TYPE_LSB  = 26;
    localparam int IMM_BIT   = 25;
    localparam int OPC_LSB   = 21;
    localparam int MEMF_LSB  = 21;
    localparam int S_BIT     = 20;
    localparam int LOAD_BIT  = 20;
    localparam int RN_LSB    = 16;
    localparam int RD_LSB    = 12;
    localparam int BX_LSB    = 4;
    localparam int IMM8_LSB  = 0;
    localparam int RM_LSB    = 0;

endpackage

// File: rtl/instr_field_pack.sv
// rtl/instr_field_pack.sv - combinational packing of instruction fields into a 32-bit word
module instr_field_pack
    import instr_pkg::*;
(
    input  logic [1:0]  cls,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        setcond,
    input  logic        imm,
    input  logic [3:0]  rn,
    input  logic [3:0]  rd,
    input  logic [3:0]  rm,
    input  logic [7:0]  imm8,
    input  logic        load,
    output logic [31:0] word,
    output logic        is_halt,
    output logic        zero_word
);

    // Assemble the word for the selected class; unused bits stay zero
    always_comb begin
        word = HALT_WORD;
        unique case (instr_class_t'(cls))
            CLS_ALU: begin
                word[COND_LSB +: 4] = cond;
                word[TYPE_LSB +: 2] = TYPE_ALU;
                word[IMM_BIT]       = imm;
                word[OPC_LSB +: 4]  = opcode;
                word[S_BIT]         = setcond;
                word[RN_LSB +: 4]   = rn;
                word[RD_LSB +: 4]   = rd;
                if (imm) begin
                    word[IMM8_LSB +: 8] = imm8;
                end else begin
                    word[RM_LSB +: 4]   = rm;
                end
            end
            CLS_MEM: begin
                word[COND_LSB +: 4] = cond;
                word[TYPE_LSB +: 2] = TYPE_MEM;
                word[MEMF_LSB +: 5] = MEM_FIXED;
                word[LOAD_BIT]      = load;
                word[RN_LSB +: 4]   = rn;
                word[RD_LSB +: 4]   = rd;
            end
            CLS_BX: begin
                word[COND_LSB +: 4] = cond;
                word[BX_LSB +: 24]  = BX_PATTERN;
                word[RM_LSB +: 4]   = rm;
            end
            default: begin
                word = HALT_WORD;
            end
        endcase
    end

    // A real instruction that packs to the halt pattern would be mistaken for a terminator
    always_comb begin
        is_halt   = (instr_class_t'(cls) == CLS_HALT);
        zero_word = !is_halt && (word == HALT_WORD);
    end

endmodule

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - program sequencer writing encoded instructions to memory
module instruction_encoder
    import instr_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_class,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_opcode,
    input  logic              in_setcond,
    input  logic              in_imm,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [7:0]        in_imm8,
    input  logic              in_load,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;

    enc_state_t        state;
    enc_state_t        next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       packed_word;
    logic              is_halt;
    logic              zero_word;
    logic              accept;

    instr_field_pack u_pack (
        .cls       (in_class),
        .cond      (in_cond),
        .opcode    (in_opcode),
        .setcond   (in_setcond),
        .imm       (in_imm),
        .rn        (in_rn),
        .rd        (in_rd),
        .rm        (in_rm),
        .imm8      (in_imm8),
        .load      (in_load),
        .word      (packed_word),
        .is_halt   (is_halt),
        .zero_word (zero_word)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and handshake/status outputs; the top slot is kept for the terminator
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        full       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) next_state = ST_RUN;
            end
            ST_RUN: begin
                in_ready = (addr_q != TOP_ADDR);
                full     = (addr_q == TOP_ADDR);
                accept   = in_valid && in_ready;
                if (accept && is_halt) begin
                    next_state = ST_DONE;
                end else if (finish) begin
                    next_state = ST_TERM;
                end
            end
            ST_TERM: begin
                next_state = ST_DONE;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) next_state = ST_RUN;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Address/count bookkeeping and the registered memory write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            count     <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            if ((state == ST_IDLE || state == ST_DONE) && start) begin
                addr_q   <= '0;
                count    <= '0;
                mem_addr <= '0;
            end else if (accept) begin
                if (zero_word) begin
                    err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= packed_word;
                    addr_q    <= addr_q + ADDR_W'(1);
                    count     <= count + (ADDR_W + 1)'(1);
                end
            end else if (state == ST_TERM) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_q;
                mem_wdata <= HALT_WORD;
                count     <= count + (ADDR_W + 1)'(1);
            end
        end
    end

endmodule
